// File: rtl/sng_pkg.sv
// Shared types and helpers for the multi-channel stochastic number generator.
// The LFSR sequence option is compiled in only when SNG_LFSR_EN is defined.
package sng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } sng_state_e;

    typedef enum logic {
        SNG_WBG  = 1'b0,
        SNG_LFSR = 1'b1
    } sng_mode_e;

    // Maximal-length Fibonacci tap masks (bit n-1 is the MSB tap) for widths 2..8.
    // Feedback is the XOR of the masked state shifted into bit 0.
    function automatic logic [7:0] lfsr_taps(input int w);
        logic [7:0] t;
        case (w)
            2:       t = 8'b0000_0011;
            3:       t = 8'b0000_0110;
            4:       t = 8'b0000_1100;
            5:       t = 8'b0001_0100;
            6:       t = 8'b0011_0000;
            7:       t = 8'b0110_0000;
            8:       t = 8'b1011_1000;
            default: t = 8'b0000_0000;
        endcase
        return t;
    endfunction

    // Stream length for a given operand width.
    function automatic int sng_len(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/sng_lfsr.sv
// Maximal-length Fibonacci LFSR, DATA_W bits, period 2^DATA_W-1.
// Seeded to 1 on reset or seed_load; never reaches the all-zero state.
module sng_lfsr
    import sng_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              i_clk_sng,
    input  logic              i_rst_sng,
    input  logic              i_seed_load,
    input  logic              i_advance,
    output logic [DATA_W-1:0] o_state
);

    localparam logic [7:0]        TAPS_FULL = lfsr_taps(DATA_W);
    localparam logic [DATA_W-1:0] TAPS      = TAPS_FULL[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SEED      = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] lfsr_q;
    logic [DATA_W-1:0] lfsr_d;

    // Seed has priority over stepping; otherwise hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_seed_load) begin
            lfsr_d = SEED;
        end else if (i_advance) begin
            lfsr_d = {lfsr_q[DATA_W-2:0], ^(lfsr_q & TAPS)};
        end
    end

    // State register, async reset to the seed value.
    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_state = lfsr_q;

endmodule

// File: rtl/sng_multi.sv
// Multi-channel stochastic number generator: NUM_CH unsigned DATA_W-bit
// operands become unipolar streams of length 2^DATA_W holding exactly x ones.
// Default build uses the weighted-binary sequence only; define SNG_LFSR_EN to
// add the LFSR comparator sequence selected by i_mode.
module sng_multi
    import sng_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int NUM_CH = 4
) (
    input  logic                     i_clk_sng,
    input  logic                     i_rst_sng,
    input  logic [NUM_CH*DATA_W-1:0] i_x_bn,
    input  logic                     i_mode,
    input  logic                     i_start_sng,
    input  logic                     i_stop_sng,
    output logic [NUM_CH-1:0]        o_sn_bits,
    output logic                     o_valid,
    output logic                     o_last,
    output logic                     o_busy
);

    localparam int L = sng_len(DATA_W);

    if (DATA_W < 2 || DATA_W > 8) begin : g_bad_width
        $error("sng_multi: DATA_W must be in 2..8");
    end

    sng_state_e                state_q, state_d;
    logic [DATA_W-1:0]         cnt_q, cnt_d;
    logic [NUM_CH*DATA_W-1:0]  x_q, x_d;
    sng_mode_e                 mode_q, mode_d;

    logic                      start_acc;
    logic                      gen;
    logic                      last_k;
    logic [NUM_CH-1:0]         wbg_bits;
    logic [NUM_CH-1:0]         lfsr_bits;
    logic [NUM_CH-1:0]         sel_bits;
    int                        t_ones;
    logic                      t_done;

    assign gen       = (state_q == GEN);
    assign start_acc = (state_q == IDLE) && i_start_sng;
    assign last_k    = &cnt_q;

    // Next-state, counter and operand/mode latch; defaults hold everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (i_start_sng) begin
                    state_d = GEN;
                    cnt_d   = '0;
                    x_d     = i_x_bn;
`ifdef SNG_LFSR_EN
                    mode_d  = i_mode ? SNG_LFSR : SNG_WBG;
`else
                    mode_d  = SNG_WBG;
`endif
                end
            end
            GEN: begin
                cnt_d = cnt_q + 1'b1;
                if (last_k || i_stop_sng) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers with async reset.
    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            mode_q  <= SNG_WBG;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            mode_q  <= mode_d;
        end
    end

    // Weighted-binary select: trailing ones of k pick operand bit MSB-first;
    // k = L-1 has DATA_W trailing ones and yields the zero padding bit.
    always_comb begin
        t_ones   = 0;
        t_done   = 1'b0;
        wbg_bits = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (!t_done && cnt_q[i]) begin
                t_ones = t_ones + 1;
            end else begin
                t_done = 1'b1;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (t_ones < DATA_W) begin
                wbg_bits[c] = x_q[c*DATA_W + (DATA_W-1-t_ones)];
            end
        end
    end

`ifdef SNG_LFSR_EN
    logic [DATA_W-1:0] lfsr_state;

    sng_lfsr #(
        .DATA_W (DATA_W)
    ) u_lfsr (
        .i_clk_sng   (i_clk_sng),
        .i_rst_sng   (i_rst_sng),
        .i_seed_load (start_acc),
        .i_advance   (gen),
        .o_state     (lfsr_state)
    );

    // Per-channel comparator on a rotated LFSR view; rotation decorrelates
    // channels while keeping the set of nonzero values, so popcount stays x.
    always_comb begin
        logic [2*DATA_W-1:0] dbl;
        logic [DATA_W-1:0]   rot;
        logic [DATA_W-1:0]   xc;
        lfsr_bits = '0;
        dbl       = '0;
        rot       = '0;
        xc        = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            dbl = {lfsr_state, lfsr_state} >> (DATA_W - (c % DATA_W));
            rot = dbl[DATA_W-1:0];
            xc  = x_q[c*DATA_W +: DATA_W];
            lfsr_bits[c] = (rot != '0) && (rot <= xc) && !last_k;
        end
    end
`else
    logic unused_mode;
    logic unused_start;

    assign unused_mode  = i_mode;
    assign unused_start = start_acc;
    assign lfsr_bits    = '0;
`endif

    // Output mux; bits are forced low outside GEN.
    always_comb begin
        sel_bits  = (mode_q == SNG_LFSR) ? lfsr_bits : wbg_bits;
        o_sn_bits = gen ? sel_bits : '0;
        o_valid   = gen;
        o_busy    = gen;
        o_last    = gen && last_k;
    end

endmodule

// File: tb/tb_sng_multi.sv
// Scoreboard bench for sng_multi (DATA_W=4, NUM_CH=4). Stimulus pushes
// hand-derived expected bits; a negedge monitor pops and compares.
module tb_sng_multi;

    localparam int DATA_W = 4;
    localparam int NUM_CH = 4;

    typedef struct packed {
        logic [NUM_CH-1:0] bits;
        logic              last;
    } exp_t;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] x_bn;
    logic                     mode;
    logic                     start;
    logic                     stop;
    logic [NUM_CH-1:0]        sn_bits;
    logic                     valid;
    logic                     last;
    logic                     busy;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    // Capture mode for streams checked by popcount rather than bit-by-bit.
    logic        bypass;
    int          pc[NUM_CH];
    logic [15:0] st0, st1;
    int          kb;
    int          last_at;

    // Stream constants: bit (15-k) is the bit emitted at cycle k.
    localparam logic [15:0] S15 = 16'hFFFE;
    localparam logic [15:0] S8  = 16'hAAAA;
    localparam logic [15:0] S1  = 16'h0100;
    localparam logic [15:0] S5  = 16'h4544;
    localparam logic [15:0] S0  = 16'h0000;

    sng_multi #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .i_clk_sng   (clk),
        .i_rst_sng   (rst),
        .i_x_bn      (x_bn),
        .i_mode      (mode),
        .i_start_sng (start),
        .i_stop_sng  (stop),
        .o_sn_bits   (sn_bits),
        .o_valid     (valid),
        .o_last      (last),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [15:0] s3, input logic [15:0] s2,
                               input logic [15:0] s1, input logic [15:0] s0, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.bits = {s3[15-k], s2[15-k], s1[15-k], s0[15-k]};
            e.last = (k == 15);
            sb.push_back(e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one tick after the edge that enters GEN (k=0 on the outputs).
    task automatic start_stream(input logic [15:0] x, input logic m);
        cyc(1);
        x_bn  = x;
        mode  = m;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Monitor: pops on every valid cycle, checks quiet outputs otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                chk("busy_gen", {31'd0, busy}, 32'd1);
                if (bypass) begin
                    for (int c = 0; c < NUM_CH; c++) pc[c] += int'(sn_bits[c]);
                    if (kb < 16) begin
                        st0[15-kb] = sn_bits[0];
                        st1[15-kb] = sn_bits[1];
                    end
                    if (last) last_at = kb;
                    kb++;
                end else if (sb.size() == 0) begin
                    chk("unexpected_valid", {31'd0, valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("bits", {28'd0, sn_bits}, {28'd0, e.bits});
                    chk("last", {31'd0, last}, {31'd0, e.last});
                end
            end else begin
                chk("idle_quiet", {29'd0, busy, last, |sn_bits}, 32'd0);
            end
        end
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        bypass  = 1'b0;
        kb      = 0;
        last_at = -1;
        st0     = '0;
        st1     = '0;
        for (int c = 0; c < NUM_CH; c++) pc[c] = 0;
        rst   = 1'b1;
        x_bn  = '0;
        mode  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #3;
        chk("reset_outputs", {26'd0, valid, busy, last, sn_bits}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: mixed operands incl. 0 and L-1
        push_stream(S15, S8, S1, S0, 16);
        start_stream({4'd15, 4'd8, 4'd1, 4'd0}, 1'b0);
        cyc(16);

        // 2: x=5 on ch0, then back to idle
        push_stream(S0, S0, S0, S5, 16);
        start_stream({4'd0, 4'd0, 4'd0, 4'd5}, 1'b0);
        cyc(16);
        chk("t2_idle_after", {30'd0, valid, busy}, 32'd0);

`ifdef SNG_LFSR_EN
        // 3: LFSR mode checked by popcount and decorrelation
        bypass = 1'b1;
        start_stream({4'd7, 4'd12, 4'd3, 4'd15}, 1'b1);
        cyc(16);
        bypass = 1'b0;
        chk("lfsr_pc3", pc[3], 7);
        chk("lfsr_pc2", pc[2], 12);
        chk("lfsr_pc1", pc[1], 3);
        chk("lfsr_pc0", pc[0], 15);
        chk("lfsr_ch0_pad", {31'd0, st0[0]}, 32'd0);
        chk("lfsr_len", kb, 16);
        chk("lfsr_last_k", last_at, 15);
        for (int c = 0; c < NUM_CH; c++) pc[c] = 0;
        kb = 0;
        last_at = -1;
        bypass = 1'b1;
        start_stream({4'd9, 4'd9, 4'd9, 4'd9}, 1'b1);
        cyc(16);
        bypass = 1'b0;
        chk("lfsr_eq_pc0", pc[0], 9);
        chk("lfsr_eq_pc1", pc[1], 9);
        chk("lfsr_ch_differ", {31'd0, st0 != st1}, 32'd1);
`else
        // i_mode is ignored without the LFSR option: WBG sequence expected
        push_stream(S0, S0, S0, S5, 16);
        start_stream({4'd0, 4'd0, 4'd0, 4'd5}, 1'b1);
        cyc(16);
`endif

        // 4: abort at k=5, then full restart two cycles later
        push_stream(S15, S8, S1, S5, 6);
        start_stream({4'd15, 4'd8, 4'd1, 4'd5}, 1'b0);
        cyc(5);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t4_idle_after_stop", {30'd0, valid, busy}, 32'd0);
        cyc(1);
        push_stream(S15, S8, S1, S5, 16);
        start_stream({4'd15, 4'd8, 4'd1, 4'd5}, 1'b0);
        cyc(16);

        // 5: operand change and start during GEN; stop during IDLE
        push_stream(S15, S8, S1, S5, 16);
        start_stream({4'd15, 4'd8, 4'd1, 4'd5}, 1'b0);
        cyc(3);
        x_bn  = '0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(12);
        stop = 1'b1;
        cyc(2);
        chk("t5_stop_in_idle", {30'd0, valid, busy}, 32'd0);
        stop = 1'b0;

        // 6: async reset mid-stream at k=9
        push_stream(S15, S8, S1, S5, 10);
        start_stream({4'd15, 4'd8, 4'd1, 4'd5}, 1'b0);
        cyc(9);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_reset", {26'd0, valid, busy, last, sn_bits}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_stream(S15, S8, S1, S5, 16);
        start_stream({4'd15, 4'd8, 4'd1, 4'd5}, 1'b0);
        cyc(16);

        cyc(2);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
